// File: rtl/timer_irq_pkg.sv
// Shared definitions for the timer interrupt generator.
//   MODE_ONESHOT / MODE_LEVEL : bit positions inside the 2-bit channel mode field
//   CFG_CNT_W / CFG_PW_W      : storage widths of the configuration record
//   DEF_PERIOD / DEF_WIDTH    : reset configuration (100 us period, 1 us pulse at 100 MHz)
//   ch_cfg_t                  : per-channel configuration record {period, width, mode}
package timer_irq_pkg;

    localparam int unsigned MODE_ONESHOT = 0;
    localparam int unsigned MODE_LEVEL   = 1;

    localparam int unsigned CFG_CNT_W = 32;
    localparam int unsigned CFG_PW_W  = 12;

    localparam int unsigned DEF_PERIOD = 10000;
    localparam int unsigned DEF_WIDTH  = 100;

    typedef struct packed {
        logic [CFG_CNT_W-1:0] period;
        logic [CFG_PW_W-1:0]  width;
        logic [1:0]           mode;
    } ch_cfg_t;

endpackage

// File: rtl/timer_irq_ch.sv
// One timer channel: configuration registers, period counter, pulse-hold counter,
// one-shot done flag, interrupt line and sticky overrun flag.
//   clk_i        : 100 MHz clock
//   rst_i        : asynchronous active-high reset
//   cfg_wr_i     : load cfg_*_i into this channel and restart it
//   cfg_period_i : period in cycles (0 = never fire)
//   cfg_width_i  : pulse width in cycles (0 treated as 1), pulse mode only
//   cfg_mode_i   : bit MODE_ONESHOT = one-shot, bit MODE_LEVEL = level output
//   en_i         : run enable (level)
//   ack_i        : acknowledge; clears level irq and the overrun flag
//   irq_o        : interrupt line (direct flop output)
//   ovf_o        : sticky overrun flag
module timer_irq_ch
    import timer_irq_pkg::*;
#(
    parameter int unsigned CntW      = CFG_CNT_W,
    parameter int unsigned PwW       = CFG_PW_W,
    parameter int unsigned DefPeriod = DEF_PERIOD,
    parameter int unsigned DefWidth  = DEF_WIDTH
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cfg_wr_i,
    input  logic [CntW-1:0] cfg_period_i,
    input  logic [PwW-1:0]  cfg_width_i,
    input  logic [1:0]      cfg_mode_i,
    input  logic            en_i,
    input  logic            ack_i,
    output logic            irq_o,
    output logic            ovf_o
);

    localparam logic [CntW-1:0] CntOne = CntW'(1);
    localparam logic [PwW-1:0]  PwOne  = PwW'(1);
    localparam ch_cfg_t CfgReset = '{
        period: CFG_CNT_W'(DefPeriod),
        width:  CFG_PW_W'(DefWidth),
        mode:   2'b00
    };

    ch_cfg_t         cfg_q, cfg_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [PwW-1:0]  hold_q, hold_d;
    logic            done_q, done_d;
    logic            irq_q, irq_d;
    logic            ovf_q, ovf_d;

    logic [CntW-1:0] period;
    logic [PwW-1:0]  width;
    logic [PwW-1:0]  hold_last;
    logic            oneshot;
    logic            level;
    logic            fire;

    assign period    = CntW'(cfg_q.period);
    assign width     = PwW'(cfg_q.width);
    // A zero width behaves as a one-cycle pulse.
    assign hold_last = (width == '0) ? '0 : width - PwOne;
    assign oneshot   = cfg_q.mode[MODE_ONESHOT];
    assign level     = cfg_q.mode[MODE_LEVEL];
    assign fire      = en_i && !done_q && (period != '0) && (cnt_q == period - CntOne);

    always_comb begin
        cfg_d  = cfg_q;
        cnt_d  = cnt_q;
        hold_d = hold_q;
        done_d = done_q;
        irq_d  = irq_q;
        ovf_d  = ovf_q;

        if (ack_i) begin
            ovf_d = 1'b0;
        end

        if (cfg_wr_i) begin
            // A write restarts the channel and beats a coincident fire.
            cfg_d = '{
                period: CFG_CNT_W'(cfg_period_i),
                width:  CFG_PW_W'(cfg_width_i),
                mode:   cfg_mode_i
            };
            cnt_d  = '0;
            hold_d = '0;
            irq_d  = 1'b0;
            done_d = 1'b0;
        end else if (!en_i) begin
            cnt_d  = '0;
            hold_d = '0;
            irq_d  = 1'b0;
            done_d = 1'b0;
        end else if (fire) begin
            cnt_d  = '0;
            hold_d = '0;
            irq_d  = 1'b1;
            done_d = oneshot;
            // Fire wins over a same-edge ack, so the overrun still registers.
            if (level && irq_q) begin
                ovf_d = 1'b1;
            end
        end else begin
            if (!done_q && (period != '0)) begin
                cnt_d = cnt_q + CntOne;
            end
            if (irq_q) begin
                if (level) begin
                    if (ack_i) begin
                        irq_d = 1'b0;
                    end
                end else if (hold_q == hold_last) begin
                    irq_d  = 1'b0;
                    hold_d = '0;
                end else begin
                    hold_d = hold_q + PwOne;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_q  <= CfgReset;
            cnt_q  <= '0;
            hold_q <= '0;
            done_q <= 1'b0;
            irq_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cfg_q  <= cfg_d;
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
            done_q <= done_d;
            irq_q  <= irq_d;
            ovf_q  <= ovf_d;
        end
    end

    assign irq_o = irq_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/timer_irq_gen.sv
// Multi-channel programmable timer interrupt generator (100 MHz domain).
//   clk_100    : system clock
//   rst_100    : asynchronous active-high reset
//   cfg_wr     : one-cycle strobe, loads cfg_period/cfg_width/cfg_mode into channel cfg_ch
//   cfg_ch     : target channel; indices >= NUM_CH are ignored
//   cfg_period : period in cycles
//   cfg_width  : pulse width in cycles
//   cfg_mode   : bit0 one-shot, bit1 level (held until ack)
//   ch_en      : per-channel run enable
//   irq_ack    : per-channel acknowledge
//   irq_out    : per-channel interrupt lines
//   irq_any    : registered OR of irq_out (one cycle behind)
//   irq_ovf    : per-channel sticky overrun flags
module timer_irq_gen
    import timer_irq_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = CFG_CNT_W,
    parameter int unsigned PW_W       = CFG_PW_W,
    parameter int unsigned DEF_PERIOD = timer_irq_pkg::DEF_PERIOD,
    parameter int unsigned DEF_WIDTH  = timer_irq_pkg::DEF_WIDTH,
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_100,
    input  logic              rst_100,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [PW_W-1:0]   cfg_width,
    input  logic [1:0]        cfg_mode,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] irq_ack,
    output logic [NUM_CH-1:0] irq_out,
    output logic              irq_any,
    output logic [NUM_CH-1:0] irq_ovf
);

    logic [NUM_CH-1:0] cfg_stb;
    logic              irq_any_q;

    // Out-of-range indices match no channel and are dropped.
    always_comb begin
        cfg_stb = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            cfg_stb[c] = cfg_wr && (32'(cfg_ch) == c);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        timer_irq_ch #(
            .CntW      (CNT_W),
            .PwW       (PW_W),
            .DefPeriod (DEF_PERIOD),
            .DefWidth  (DEF_WIDTH)
        ) u_ch (
            .clk_i        (clk_100),
            .rst_i        (rst_100),
            .cfg_wr_i     (cfg_stb[c]),
            .cfg_period_i (cfg_period),
            .cfg_width_i  (cfg_width),
            .cfg_mode_i   (cfg_mode),
            .en_i         (ch_en[c]),
            .ack_i        (irq_ack[c]),
            .irq_o        (irq_out[c]),
            .ovf_o        (irq_ovf[c])
        );
    end

    always_ff @(posedge clk_100 or posedge rst_100) begin
        if (rst_100) begin
            irq_any_q <= 1'b0;
        end else begin
            irq_any_q <= |irq_out;
        end
    end

    assign irq_any = irq_any_q;

endmodule
